// File: rtl/cdb_arbiter_pkg.sv
// Shared widths and record type for the CDB wakeup arbiter and its per-FU skid buffers.
package cdb_arbiter_pkg;

  localparam int PREG_W    = 7;
  localparam int ROB_IDX_W = 4;
  localparam int CDB_PORTS = 3;

  typedef struct packed {
    logic [PREG_W-1:0]    tag;
    logic [ROB_IDX_W-1:0] rob_index;
  } cdb_entry_t;

  // Increment with wrap for moduli that need not be a power of two.
  function automatic int wrap_inc(input int idx, input int modulus);
    return (idx + 1 >= modulus) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/cdb_skid_fifo.sv
// Small FIFO that holds completed-tag records for one functional unit until a CDB slot frees up.
module cdb_skid_fifo
  import cdb_arbiter_pkg::*;
#(
  parameter int SKID_DEPTH = 2
)
(
  input  logic       clk,
  input  logic       reset,
  input  logic       flush,
  input  logic       push,
  input  cdb_entry_t push_data,
  input  logic       pop,
  output cdb_entry_t head,
  output logic       empty,
  output logic       full
);

  localparam int PTR_W = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
  localparam int CNT_W = $clog2(SKID_DEPTH) + 1;

  cdb_entry_t       mem [SKID_DEPTH];
  logic [PTR_W-1:0] head_ptr;
  logic [PTR_W-1:0] tail_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(SKID_DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign head    = mem[head_ptr];

  // A full buffer refuses a push even when it is being drained this cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else if (flush) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else begin
      if (do_push) begin
        tail_ptr <= PTR_W'(wrap_inc(int'(tail_ptr), SKID_DEPTH));
      end
      if (do_pop) begin
        head_ptr <= PTR_W'(wrap_inc(int'(head_ptr), SKID_DEPTH));
      end
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[tail_ptr] <= push_data;
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin sharing of the three registered CDB wakeup slots among N_FU completing units.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int N_FU       = 4,
  parameter int SKID_DEPTH = 2
)
(
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush,
  input  logic [N_FU-1:0]           fu_valid,
  input  logic [N_FU*PREG_W-1:0]    fu_tag,
  input  logic [N_FU*ROB_IDX_W-1:0] fu_rob,
  output logic [N_FU-1:0]           fu_ready,
  output logic [PREG_W-1:0]         reg1_rdy,
  output logic [PREG_W-1:0]         reg2_rdy,
  output logic [PREG_W-1:0]         reg3_rdy,
  output logic                      reg1_rdy_valid,
  output logic                      reg2_rdy_valid,
  output logic                      reg3_rdy_valid,
  output logic [ROB_IDX_W-1:0]      reg1_rob,
  output logic [ROB_IDX_W-1:0]      reg2_rob,
  output logic [ROB_IDX_W-1:0]      reg3_rob
);

  localparam int RR_W = $clog2(N_FU);

  logic [N_FU-1:0]      fifo_empty;
  logic [N_FU-1:0]      fifo_full;
  cdb_entry_t           fifo_head  [N_FU];
  cdb_entry_t           push_entry [N_FU];
  logic [RR_W-1:0]      scan_idx   [N_FU];
  logic [N_FU-1:0]      grant;
  logic [RR_W-1:0]      rr_ptr;
  logic [RR_W-1:0]      last_idx;
  logic [RR_W-1:0]      next_rr;
  logic [1:0]           n_grant;
  logic [CDB_PORTS-1:0] slot_valid;
  cdb_entry_t           slot_data  [CDB_PORTS];

  assign fu_ready = ~fifo_full;

  for (genvar g = 0; g < N_FU; g++) begin : g_fu
    assign push_entry[g] = {fu_tag[g*PREG_W +: PREG_W], fu_rob[g*ROB_IDX_W +: ROB_IDX_W]};
    assign scan_idx[g]   = RR_W'((int'(rr_ptr) + g) % N_FU);

    cdb_skid_fifo #(
      .SKID_DEPTH(SKID_DEPTH)
    ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .push      (fu_valid[g] & fu_ready[g]),
      .push_data (push_entry[g]),
      .pop       (grant[g]),
      .head      (fifo_head[g]),
      .empty     (fifo_empty[g]),
      .full      (fifo_full[g])
    );
  end

  // Walk FUs starting at rr_ptr; the first three non-empty buffers take slots 1..3 in scan order.
  always_comb begin
    grant    = '0;
    n_grant  = '0;
    last_idx = rr_ptr;
    for (int s = 0; s < CDB_PORTS; s++) begin
      slot_valid[s] = 1'b0;
      slot_data[s]  = '0;
    end
    for (int k = 0; k < N_FU; k++) begin
      if (!fifo_empty[scan_idx[k]] && (n_grant < 2'(CDB_PORTS))) begin
        grant[scan_idx[k]]  = 1'b1;
        slot_valid[n_grant] = 1'b1;
        slot_data[n_grant]  = fifo_head[scan_idx[k]];
        last_idx            = scan_idx[k];
        n_grant             = n_grant + 2'd1;
      end
    end
  end

  assign next_rr = RR_W'(wrap_inc(int'(last_idx), N_FU));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr         <= '0;
      reg1_rdy_valid <= 1'b0;
      reg2_rdy_valid <= 1'b0;
      reg3_rdy_valid <= 1'b0;
      reg1_rdy       <= '0;
      reg2_rdy       <= '0;
      reg3_rdy       <= '0;
      reg1_rob       <= '0;
      reg2_rob       <= '0;
      reg3_rob       <= '0;
    end else if (flush) begin
      rr_ptr         <= '0;
      reg1_rdy_valid <= 1'b0;
      reg2_rdy_valid <= 1'b0;
      reg3_rdy_valid <= 1'b0;
      reg1_rdy       <= '0;
      reg2_rdy       <= '0;
      reg3_rdy       <= '0;
      reg1_rob       <= '0;
      reg2_rob       <= '0;
      reg3_rob       <= '0;
    end else begin
      if (|grant) begin
        rr_ptr <= next_rr;
      end
      reg1_rdy_valid <= slot_valid[0];
      reg2_rdy_valid <= slot_valid[1];
      reg3_rdy_valid <= slot_valid[2];
      reg1_rdy       <= slot_data[0].tag;
      reg2_rdy       <= slot_data[1].tag;
      reg3_rdy       <= slot_data[2].tag;
      reg1_rob       <= slot_data[0].rob_index;
      reg2_rob       <= slot_data[1].rob_index;
      reg3_rob       <= slot_data[2].rob_index;
    end
  end

endmodule
